// File: rtl/bpsk_pkg.sv
// ---------------------------------------------------------------------------
// bpsk_pkg
// Shared definitions for the BPSK transmit path: default payload size,
// the frame scheduler state encoding, the packet source encoding and a small
// helper used to size symbol counters at elaboration time.
// ---------------------------------------------------------------------------
package bpsk_pkg;

   localparam int PACKET_SIZE = 184;

   // Frame phases, in the order they are transmitted
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_PAYLOAD  = 2'd2,
      ST_GUARD    = 2'd3
   } txState_t;

   // Packet sources competing for the transmitter
   typedef enum logic {
      SRC_DATA = 1'b0,
      SRC_BCN  = 1'b1
   } txSrc_t;

   // Largest of three lengths, used to pick one counter width for all phases
   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// tx_frame_scheduler_if
// Bundles the packet-source handshakes and the modulator-side signals of the
// frame scheduler.
//   data_req/data_packet/data_ack : UART buffer request, packet, capture pulse
//   bcn_req/bcn_packet/bcn_ack    : beacon request, packet, capture pulse
//   sym_next                      : symbol-boundary strobe from the modulator
//   tx_bit/tx_en                  : current symbol and carrier enable
//   busy/frame_done               : status to the rest of the system
// Modports: master = sources + modulator side, slave = the scheduler.
// ---------------------------------------------------------------------------
interface tx_frame_scheduler_if #(
   parameter int PACKET_SIZE = bpsk_pkg::PACKET_SIZE
) ();

   logic                   data_req;
   logic [PACKET_SIZE-1:0] data_packet;
   logic                   data_ack;
   logic                   bcn_req;
   logic [PACKET_SIZE-1:0] bcn_packet;
   logic                   bcn_ack;
   logic                   sym_next;
   logic                   tx_bit;
   logic                   tx_en;
   logic                   busy;
   logic                   frame_done;

   modport master (
      output data_req, data_packet, bcn_req, bcn_packet, sym_next,
      input  data_ack, bcn_ack, tx_bit, tx_en, busy, frame_done
   );

   modport slave (
      input  data_req, data_packet, bcn_req, bcn_packet, sym_next,
      output data_ack, bcn_ack, tx_bit, tx_en, busy, frame_done
   );

endinterface

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. Bit 0 is the data source, bit 1 the beacon.
// A lone requester always wins; on contention the source that was not
// granted last wins. The last-grant register resets to beacon so data wins
// the first contention.
//   clk, rst   : clock, asynchronous active-high reset
//   i_en       : arbitration allowed this cycle
//   i_req[1:0] : {beacon, data} request levels
//   o_grant    : one-hot grant, all zero when disabled or no request
// ---------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_grant
);
   import bpsk_pkg::*;

   txSrc_t r_lastGrant;

   // Grant decision: purely combinational so the scheduler can load the
   // winner's packet on the same cycle the request is seen
   always_comb begin
      o_grant = 2'b00;
      if (i_en) begin
         case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_lastGrant == SRC_BCN) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
         endcase
      end
   end

   // Remember who won so the other source gets the next contention
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lastGrant <= SRC_BCN;
      end else if (o_grant != 2'b00) begin
         r_lastGrant <= o_grant[1] ? SRC_BCN : SRC_DATA;
      end
   end

endmodule

// File: rtl/tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tx_frame_scheduler
// Picks a packet from the UART buffer or the beacon source, captures it and
// streams one frame to the BPSK modulator: an alternating 1/0 preamble, the
// payload MSB first, then a run of zero guard symbols. The modulator paces
// everything through sym_next.
//   clk  : system clock, all state on the rising edge
//   rst  : asynchronous active-high reset, aborts any frame in flight
//   bus  : tx_frame_scheduler_if.slave (source handshakes, modulator side)
// Parameters: PACKET_SIZE payload bits, PREAMBLE_LEN preamble symbols
// (even, >=2), GUARD_LEN trailing zero symbols (>=1).
// ---------------------------------------------------------------------------
module tx_frame_scheduler #(
   parameter int PACKET_SIZE  = bpsk_pkg::PACKET_SIZE,
   parameter int PREAMBLE_LEN = 16,
   parameter int GUARD_LEN    = 8
) (
   input logic                 clk,
   input logic                 rst,
   tx_frame_scheduler_if.slave bus
);
   import bpsk_pkg::*;

   localparam int CNT_W = $clog2(maxOf3(PREAMBLE_LEN, PACKET_SIZE, GUARD_LEN) + 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
   localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PACKET_SIZE - 1);
   localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_LEN - 1);

   txState_t               r_state;
   txState_t               w_nextState;
   logic [CNT_W-1:0]       r_symCnt;
   logic [PACKET_SIZE-1:0] r_shiftReg;
   logic                   r_dataAck;
   logic                   r_bcnAck;
   logic                   r_frameDone;
   logic [1:0]             w_grant;
   logic                   w_idle;

   assign w_idle = (r_state == ST_IDLE);

   // Arbitration only happens in IDLE, so requests arriving mid-frame just
   // wait at the arbiter input until the frame is over
   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_idle),
      .i_req   ({bus.bcn_req, bus.data_req}),
      .o_grant (w_grant)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: each phase ends on the sym_next that completes its
   // last symbol; leaving IDLE needs only a grant
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:     if (w_grant != 2'b00)                     w_nextState = ST_PREAMBLE;
         ST_PREAMBLE: if (bus.sym_next && r_symCnt == PRE_LAST) w_nextState = ST_PAYLOAD;
         ST_PAYLOAD:  if (bus.sym_next && r_symCnt == PAY_LAST) w_nextState = ST_GUARD;
         ST_GUARD:    if (bus.sym_next && r_symCnt == GRD_LAST) w_nextState = ST_IDLE;
         default:                                               w_nextState = ST_IDLE;
      endcase
   end

   // Symbol counter: counts sym_next strobes within the current phase and
   // restarts from zero whenever the phase changes. sym_next in IDLE, which
   // includes the grant cycle, never counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_symCnt <= '0;
      end else if (w_nextState != r_state) begin
         r_symCnt <= '0;
      end else if (!w_idle && bus.sym_next) begin
         r_symCnt <= r_symCnt + 1'b1;
      end
   end

   // Payload shift register: loaded from the winning source on the grant
   // cycle, so later changes at the source cannot reach the frame; shifts
   // left once per payload symbol so the MSB is always the current bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shiftReg <= '0;
      end else if (w_idle && w_grant != 2'b00) begin
         r_shiftReg <= w_grant[1] ? bus.bcn_packet : bus.data_packet;
      end else if (r_state == ST_PAYLOAD && bus.sym_next) begin
         r_shiftReg <= {r_shiftReg[PACKET_SIZE-2:0], 1'b0};
      end
   end

   // One-cycle status pulses. Registering the grant puts the ack in the
   // first PREAMBLE cycle; frame_done lands in the first IDLE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dataAck   <= 1'b0;
         r_bcnAck    <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         r_dataAck   <= w_grant[0];
         r_bcnAck    <= w_grant[1];
         r_frameDone <= (r_state == ST_GUARD) && (w_nextState == ST_IDLE);
      end
   end

   // Output decode: preamble toggles with the counter LSB starting at 1,
   // payload is the shift register MSB, guard and idle send zero
   always_comb begin
      bus.tx_en      = !w_idle;
      bus.busy       = !w_idle;
      bus.tx_bit     = 1'b0;
      bus.data_ack   = r_dataAck;
      bus.bcn_ack    = r_bcnAck;
      bus.frame_done = r_frameDone;
      case (r_state)
         ST_PREAMBLE: bus.tx_bit = ~r_symCnt[0];
         ST_PAYLOAD:  bus.tx_bit = r_shiftReg[PACKET_SIZE-1];
         default:     bus.tx_bit = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_frame_scheduler
// Directed bench for tx_frame_scheduler: a table of frames run back to back
// through the round-robin arbiter, then hand-written sequences for a request
// arriving mid-frame and a reset that aborts a frame. Every transmitted
// symbol is compared against a reference built from the packet.
// ---------------------------------------------------------------------------
module tb_tx_frame_scheduler;

   localparam int PS    = 184;
   localparam int PL    = 16;
   localparam int GL    = 8;
   localparam int FRAME = PL + PS + GL;

   typedef struct {
      logic          dataReq;
      logic          bcnReq;
      logic [PS-1:0] dataPkt;
      logic [PS-1:0] bcnPkt;
      logic          expData;
      int            stallAt;
   } frameVec_t;

   logic clk;
   logic rst;

   int checks       = 0;
   int failures     = 0;
   int dataAckCount = 0;
   int bcnAckCount  = 0;
   int doneCount    = 0;
   int bothAckCount = 0;

   logic [PS-1:0] hookPkt;
   frameVec_t     vecs [5];

   tx_frame_scheduler_if #(.PACKET_SIZE(PS)) bus ();

   tx_frame_scheduler #(
      .PACKET_SIZE  (PS),
      .PREAMBLE_LEN (PL),
      .GUARD_LEN    (GL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edge active
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters, sampled on the inactive edge
   always @(negedge clk) begin
      if (bus.data_ack)                dataAckCount++;
      if (bus.bcn_ack)                 bcnAckCount++;
      if (bus.frame_done)              doneCount++;
      if (bus.data_ack && bus.bcn_ack) bothAckCount++;
   end

   // Hard stop in case something keeps the bench from finishing
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference symbol stream for one frame
   function automatic logic symbolOf(input logic [PS-1:0] pkt, input int i);
      if (i < PL)      return (i % 2) == 0;
      if (i < PL + PS) return pkt[PS-1-(i-PL)];
      return 1'b0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic dReq, input logic bReq,
                                input logic [PS-1:0] dPkt, input logic [PS-1:0] bPkt);
      bus.data_req    = dReq;
      bus.bcn_req     = bReq;
      bus.data_packet = dPkt;
      bus.bcn_packet  = bPkt;
   endtask

   // Runs one frame starting from IDLE with requests already driven. Drives
   // sym_next on the grant cycle (must be ignored), checks the ack pulse,
   // scrambles both sources after capture, then strobes every symbol with a
   // gap cycle between strobes. Optional hooks: raise bcn_req at symbol
   // raiseBcnAt, hold sym_next low 1000 cycles at stallAt, reset at abortAt.
   // Returns half a cycle after the edge that should raise frame_done.
   task automatic runFrame(input logic [PS-1:0] pkt, input logic expData,
                           input int raiseBcnAt, input int stallAt, input int abortAt);
      int   d0, b0, f0, bitErrs, stallErrs;
      logic expBit;
      d0 = dataAckCount;
      b0 = bcnAckCount;
      f0 = doneCount;
      bitErrs = 0;
      bus.sym_next = 1'b1;
      @(negedge clk); #1;
      bus.sym_next = 1'b0;
      checkOutput("ack data first cycle", 32'(bus.data_ack), 32'(expData));
      checkOutput("ack bcn first cycle", 32'(bus.bcn_ack), 32'(!expData));
      checkOutput("tx_en in preamble", 32'(bus.tx_en), 32'd1);
      bus.data_packet = ~bus.data_packet;
      bus.bcn_packet  = ~bus.bcn_packet;
      for (int i = 0; i < FRAME; i++) begin
         if (i == abortAt) begin
            rst = 1'b1;
            #1;
            checkOutput("async reset tx_en", 32'(bus.tx_en), 32'd0);
            checkOutput("async reset busy", 32'(bus.busy), 32'd0);
            checkOutput("async reset tx_bit", 32'(bus.tx_bit), 32'd0);
            repeat (2) begin @(negedge clk); #1; end
            checkOutput("no frame_done after abort", 32'(doneCount - f0), 32'd0);
            checkOutput("acks low in reset", 32'({bus.data_ack, bus.bcn_ack}), 32'd0);
            checkOutput("aborted frame acks", 32'((dataAckCount - d0) + (bcnAckCount - b0)), 32'd1);
            rst = 1'b0;
            return;
         end
         if (i == raiseBcnAt) begin
            bus.bcn_packet = hookPkt;
            bus.bcn_req    = 1'b1;
         end
         expBit = symbolOf(pkt, i);
         if (bus.tx_bit !== expBit || bus.tx_en !== 1'b1) bitErrs++;
         if (i == stallAt) begin
            stallErrs = 0;
            repeat (1000) begin
               @(negedge clk); #1;
               if (bus.tx_bit !== expBit || bus.tx_en !== 1'b1) stallErrs++;
            end
            checkOutput("stall holds symbol", 32'(stallErrs), 32'd0);
         end
         bus.sym_next = 1'b1;
         @(negedge clk); #1;
         bus.sym_next = 1'b0;
         if (i != FRAME - 1) begin
            @(negedge clk); #1;
         end
      end
      checkOutput("frame symbol errors", 32'(bitErrs), 32'd0);
      checkOutput("frame_done pulse", 32'(bus.frame_done), 32'd1);
      checkOutput("tx_en after frame", 32'(bus.tx_en), 32'd0);
      checkOutput("busy after frame", 32'(bus.busy), 32'd0);
      checkOutput("data acks in frame", 32'(dataAckCount - d0), 32'(expData));
      checkOutput("bcn acks in frame", 32'(bcnAckCount - b0), 32'(!expData));
      checkOutput("frame_done count", 32'(doneCount - f0), 32'd1);
   endtask

   initial begin
      // Frames run back to back; expected winners follow from the last-grant
      // register starting at beacon
      vecs[0] = '{1'b1, 1'b0, 184'h1,          {23{8'hC3}}, 1'b1, -1};
      vecs[1] = '{1'b0, 1'b1, {23{8'h5A}},     {23{8'h0F}}, 1'b0, -1};
      vecs[2] = '{1'b1, 1'b1, {23{8'hA5}},     {23{8'h3C}}, 1'b1, PL + 40};
      vecs[3] = '{1'b1, 1'b1, {8{23'h2AAAAB}}, {23{8'h96}}, 1'b0, -1};
      vecs[4] = '{1'b1, 1'b1, {23{8'h81}},     {23{8'h7E}}, 1'b1, -1};
      hookPkt = {23{8'hE7}};

      rst = 1'b1;
      bus.sym_next = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("reset tx_en", 32'(bus.tx_en), 32'd0);
      checkOutput("reset tx_bit", 32'(bus.tx_bit), 32'd0);
      checkOutput("reset busy", 32'(bus.busy), 32'd0);
      checkOutput("reset acks", 32'({bus.data_ack, bus.bcn_ack}), 32'd0);
      checkOutput("reset frame_done", 32'(bus.frame_done), 32'd0);
      rst = 1'b0;

      // sym_next with nothing to send must not start anything
      repeat (3) begin
         bus.sym_next = 1'b1;
         @(negedge clk); #1;
         bus.sym_next = 1'b0;
      end
      checkOutput("idle ignores sym_next busy", 32'(bus.busy), 32'd0);
      checkOutput("idle ignores sym_next tx_en", 32'(bus.tx_en), 32'd0);

      // Table of back-to-back frames; the next vector's requests go in on
      // the frame_done cycle so the grant leaves exactly one IDLE cycle
      applyStimulus(vecs[0].dataReq, vecs[0].bcnReq, vecs[0].dataPkt, vecs[0].bcnPkt);
      for (int k = 0; k < 5; k++) begin
         runFrame(vecs[k].expData ? vecs[k].dataPkt : vecs[k].bcnPkt,
                  vecs[k].expData, -1, vecs[k].stallAt, -1);
         if (k < 4)
            applyStimulus(vecs[k+1].dataReq, vecs[k+1].bcnReq, vecs[k+1].dataPkt, vecs[k+1].bcnPkt);
         else
            applyStimulus(1'b0, 1'b0, '0, '0);
      end
      @(negedge clk); #1;
      checkOutput("idle frame_done low", 32'(bus.frame_done), 32'd0);
      checkOutput("idle busy low", 32'(bus.busy), 32'd0);

      // Beacon request arriving mid-payload waits for the data frame to end
      applyStimulus(1'b1, 1'b0, {23{8'h69}}, '0);
      runFrame({23{8'h69}}, 1'b1, PL + 90, -1, -1);
      bus.data_req = 1'b0;
      runFrame(hookPkt, 1'b0, -1, -1, -1);
      bus.bcn_req = 1'b0;

      // Reset 50 symbols into the payload, then contention restarts cleanly
      // with data winning because last-grant is back to beacon
      applyStimulus(1'b1, 1'b0, {23{8'h33}}, '0);
      runFrame({23{8'h33}}, 1'b1, -1, -1, PL + 50);
      applyStimulus(1'b1, 1'b1, {23{8'hD2}}, {23{8'h4B}});
      runFrame({23{8'hD2}}, 1'b1, -1, -1, -1);
      applyStimulus(1'b0, 1'b0, '0, '0);
      @(negedge clk); #1;
      checkOutput("final idle busy", 32'(bus.busy), 32'd0);
      checkOutput("never both acks", 32'(bothAckCount), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
